// File: rtl/proc_io_hub_pkg.sv
// Shared constants and helpers for the processor I/O hub.
// Holds default widths, clog2 and strobe-decoding functions.
package proc_io_pkg;

    localparam int NBIN_DEF  = 19;
    localparam int NBOUT_DEF = 28;
    localparam int NPORT_DEF = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int lsb_idx(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic multi_hot(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/proc_io_hub_sync_fifo.sv
// Synchronous FIFO with registered head and occupancy count.
// A push into a full FIFO is accepted only when a pop happens together.
module sync_fifo
    import proc_io_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [clog2(DEPTH):0] count_o
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Next pointers and count; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/proc_io_hub.sv
// Peripheral-side I/O hub for the floating-point processor wrapper.
// Optional macro PROC_IO_HUB_BYPASS_EN: empty-port read returns same-cycle push.
module proc_io_hub
    import proc_io_pkg::*;
#(
    parameter int NUIOIN = NPORT_DEF,
    parameter int NUIOOU = NPORT_DEF,
    parameter int NBIN   = NBIN_DEF,
    parameter int NBOUT  = NBOUT_DEF,
    parameter int FDEPTH = 4,
    parameter int ODEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NBIN-1:0]           s_data,
    input  logic [clog2(NUIOIN)-1:0]  s_port,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [NUIOIN-1:0]         req_in,
    output logic [NBIN-1:0]           io_in,
    input  logic [NUIOOU-1:0]         out_en,
    input  logic [NBOUT-1:0]          io_out,
    output logic [NBOUT-1:0]          m_data,
    output logic [clog2(NUIOOU)-1:0]  m_port,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      underflow,
    output logic                      overflow,
    output logic                      strobe_err
);
    localparam int IPW = clog2(NUIOIN);
    localparam int OPW = clog2(NUIOOU);
    localparam int OW  = NBOUT + OPW;

    logic [NUIOIN-1:0]                 in_full, in_empty, in_push, in_pop;
    logic [NBIN-1:0]                   in_head [NUIOIN];
    logic [NUIOIN-1:0][clog2(FDEPTH):0] in_cnt;
    logic [NBIN-1:0]                   last_q [NUIOIN];
    logic [2**IPW-1:0]                 port_full;
    logic [IPW-1:0]                    rd_idx;
    logic                              rd_any, push_ok, bypass;
    logic                              o_push, o_pop, o_full, o_empty;
    logic [OW-1:0]                     o_head;
    logic [clog2(ODEPTH):0]            o_cnt;
    logic                              underflow_q, underflow_d;
    logic                              overflow_q, overflow_d;
    logic                              strobe_err_q, strobe_err_d;
    logic                              unused_cnt;

    // Out-of-range port numbers look permanently full.
    always_comb begin
        port_full = '1;
        for (int i = 0; i < NUIOIN; i++) port_full[i] = in_full[i];
    end

    assign s_ready = !rst && !port_full[s_port];
    assign push_ok = s_valid && s_ready;
    assign rd_any  = |req_in;
    assign rd_idx  = IPW'(lsb_idx(32'(req_in)));

`ifdef PROC_IO_HUB_BYPASS_EN
    assign bypass = rd_any && in_empty[rd_idx] && push_ok && (s_port == rd_idx);
`else
    assign bypass = 1'b0;
`endif

    for (genvar g = 0; g < NUIOIN; g++) begin : g_in
        assign in_push[g] = push_ok && (s_port == IPW'(g)) && !bypass;
        assign in_pop[g]  = rd_any && (rd_idx == IPW'(g)) && !in_empty[g];
        sync_fifo #(.WIDTH(NBIN), .DEPTH(FDEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (in_push[g]),
            .pop_i   (in_pop[g]),
            .data_i  (s_data),
            .head_o  (in_head[g]),
            .full_o  (in_full[g]),
            .empty_o (in_empty[g]),
            .count_o (in_cnt[g])
        );
    end

    // Serve the lowest strobed port: head, bypassed sample or last value.
    always_comb begin
        io_in = '0;
        if (rd_any) begin
            if (!in_empty[rd_idx]) io_in = in_head[rd_idx];
            else if (bypass)       io_in = s_data;
            else                   io_in = last_q[rd_idx];
        end
    end

    // Remember the value most recently delivered from each port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUIOIN; i++) last_q[i] <= '0;
        end else if (rd_any && (!in_empty[rd_idx] || bypass)) begin
            last_q[rd_idx] <= io_in;
        end
    end

    assign o_push  = |out_en;
    assign o_pop   = m_valid && m_ready;
    assign m_valid = !o_empty;
    assign {m_port, m_data} = o_head;

    sync_fifo #(.WIDTH(OW), .DEPTH(ODEPTH)) u_ofifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (o_push),
        .pop_i   (o_pop),
        .data_i  ({OPW'(lsb_idx(32'(out_en))), io_out}),
        .head_o  (o_head),
        .full_o  (o_full),
        .empty_o (o_empty),
        .count_o (o_cnt)
    );

    assign unused_cnt = ^{in_cnt, o_cnt};

    // Sticky error flags accumulate until reset.
    always_comb begin
        underflow_d  = underflow_q |
                       (rd_any && in_empty[rd_idx] && !bypass);
        overflow_d   = overflow_q | (o_push && o_full && !o_pop);
        strobe_err_d = strobe_err_q |
                       multi_hot(32'(req_in)) | multi_hot(32'(out_en));
    end

    // Flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
            strobe_err_q <= 1'b0;
        end else begin
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
            strobe_err_q <= strobe_err_d;
        end
    end

    assign underflow  = underflow_q;
    assign overflow   = overflow_q;
    assign strobe_err = strobe_err_q;

endmodule
